// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// mips_cpu_pkg: shared encodings and instruction classifier for the sequencer
// rev 1.0
// ============================================================================
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC1  = 3'd2,
    EXEC2  = 3'd3,
    EXEC3  = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    IC_ILLEGAL, IC_RALU, IC_ALUI, IC_BEQ, IC_BRANCH, IC_BRLINK, IC_J, IC_JAL,
    IC_JR, IC_JALR, IC_LOAD, IC_STORE, IC_MULDIV, IC_MFHILO, IC_MTHILO
  } iclass_t;

  localparam logic [5:0] c_op_special = 6'h00;
  localparam logic [5:0] c_op_regimm  = 6'h01;
  localparam logic [5:0] c_op_j       = 6'h02;
  localparam logic [5:0] c_op_jal     = 6'h03;
  localparam logic [5:0] c_op_beq     = 6'h04;
  localparam logic [5:0] c_op_addiu   = 6'h09;
  localparam logic [5:0] c_op_andi    = 6'h0C;
  localparam logic [5:0] c_op_ori     = 6'h0D;
  localparam logic [5:0] c_op_xori    = 6'h0E;
  localparam logic [5:0] c_op_lb      = 6'h20;
  localparam logic [5:0] c_op_lh      = 6'h21;
  localparam logic [5:0] c_op_lw      = 6'h23;
  localparam logic [5:0] c_op_lbu     = 6'h24;
  localparam logic [5:0] c_op_lhu     = 6'h25;
  localparam logic [5:0] c_op_sb      = 6'h28;
  localparam logic [5:0] c_op_sh      = 6'h29;
  localparam logic [5:0] c_op_sw      = 6'h2B;

  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_srl   = 6'h02;
  localparam logic [5:0] c_fn_sra   = 6'h03;
  localparam logic [5:0] c_fn_sllv  = 6'h04;
  localparam logic [5:0] c_fn_srlv  = 6'h06;
  localparam logic [5:0] c_fn_srav  = 6'h07;
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_jalr  = 6'h09;
  localparam logic [5:0] c_fn_mfhi  = 6'h10;
  localparam logic [5:0] c_fn_mthi  = 6'h11;
  localparam logic [5:0] c_fn_mflo  = 6'h12;
  localparam logic [5:0] c_fn_mtlo  = 6'h13;
  localparam logic [5:0] c_fn_mult  = 6'h18;
  localparam logic [5:0] c_fn_multu = 6'h19;
  localparam logic [5:0] c_fn_div   = 6'h1A;
  localparam logic [5:0] c_fn_divu  = 6'h1B;
  localparam logic [5:0] c_fn_addu  = 6'h21;
  localparam logic [5:0] c_fn_subu  = 6'h23;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_xor   = 6'h26;
  localparam logic [5:0] c_fn_nor   = 6'h27;
  localparam logic [5:0] c_fn_slt   = 6'h2A;
  localparam logic [5:0] c_fn_sltu  = 6'h2B;

  localparam logic [4:0] c_rt_bltz   = 5'h00;
  localparam logic [4:0] c_rt_bgez   = 5'h01;
  localparam logic [4:0] c_rt_bltzal = 5'h10;
  localparam logic [4:0] c_rt_bgezal = 5'h11;

  // ALU_FUNCT hands fncode decoding (R-type and mul/div ops) to the datapath
  localparam logic [3:0] c_alu_add   = 4'd0;
  localparam logic [3:0] c_alu_sub   = 4'd1;
  localparam logic [3:0] c_alu_funct = 4'd2;
  localparam logic [3:0] c_alu_and   = 4'd3;
  localparam logic [3:0] c_alu_or    = 4'd4;
  localparam logic [3:0] c_alu_xor   = 4'd5;
  localparam logic [3:0] c_alu_ltz   = 4'd6;
  localparam logic [3:0] c_alu_gez   = 4'd7;
  localparam logic [3:0] c_alu_link  = 4'd8;
  localparam logic [3:0] c_alu_ldb   = 4'd9;
  localparam logic [3:0] c_alu_ldbu  = 4'd10;
  localparam logic [3:0] c_alu_ldh   = 4'd11;
  localparam logic [3:0] c_alu_ldhu  = 4'd12;
  localparam logic [3:0] c_alu_ldw   = 4'd13;

  localparam logic [1:0] c_pcs_alu    = 2'd0;
  localparam logic [1:0] c_pcs_aluout = 2'd1;
  localparam logic [1:0] c_pcs_jump   = 2'd2;
  localparam logic [1:0] c_pcs_reg    = 2'd3;

  localparam logic [2:0] c_srcb_reg   = 3'd0;
  localparam logic [2:0] c_srcb_four  = 3'd1;
  localparam logic [2:0] c_srcb_imm   = 3'd2;
  localparam logic [2:0] c_srcb_immsh = 3'd3;
  localparam logic [2:0] c_srcb_immz  = 3'd4;

  localparam logic [1:0] c_dst_rt = 2'd0;
  localparam logic [1:0] c_dst_rd = 2'd1;
  localparam logic [1:0] c_dst_ra = 2'd2;

  // Access size codes equal opcode[1:0] of the load/store encodings
  localparam logic [1:0] c_sz_byte = 2'd0;
  localparam logic [1:0] c_sz_half = 2'd1;
  localparam logic [1:0] c_sz_word = 2'd3;

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] rt, input logic en_sub,
                                       input logic en_md);
    iclass_t cls;
    cls = IC_ILLEGAL;
    case (op)
      c_op_special: begin
        case (fn)
          c_fn_sll, c_fn_srl, c_fn_sra, c_fn_sllv, c_fn_srlv, c_fn_srav,
          c_fn_addu, c_fn_subu, c_fn_and, c_fn_or, c_fn_xor, c_fn_nor,
          c_fn_slt, c_fn_sltu:                       cls = IC_RALU;
          c_fn_jr:                                   cls = IC_JR;
          c_fn_jalr:                                 cls = IC_JALR;
          c_fn_mult, c_fn_multu, c_fn_div, c_fn_divu: cls = en_md ? IC_MULDIV : IC_ILLEGAL;
          c_fn_mfhi, c_fn_mflo:                      cls = en_md ? IC_MFHILO : IC_ILLEGAL;
          c_fn_mthi, c_fn_mtlo:                      cls = en_md ? IC_MTHILO : IC_ILLEGAL;
          default:                                   cls = IC_ILLEGAL;
        endcase
      end
      c_op_regimm: begin
        case (rt)
          c_rt_bltz, c_rt_bgez:     cls = IC_BRANCH;
          c_rt_bltzal, c_rt_bgezal: cls = IC_BRLINK;
          default:                  cls = IC_ILLEGAL;
        endcase
      end
      c_op_j:                                      cls = IC_J;
      c_op_jal:                                    cls = IC_JAL;
      c_op_beq:                                    cls = IC_BEQ;
      c_op_addiu, c_op_andi, c_op_ori, c_op_xori:  cls = IC_ALUI;
      c_op_lw:                                     cls = IC_LOAD;
      c_op_lb, c_op_lbu, c_op_lh, c_op_lhu:        cls = en_sub ? IC_LOAD : IC_ILLEGAL;
      c_op_sw:                                     cls = IC_STORE;
      c_op_sb, c_op_sh:                            cls = en_sub ? IC_STORE : IC_ILLEGAL;
      default:                                     cls = IC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_bytelane.sv
`default_nettype none
// ============================================================================
// mips_cpu_bytelane: byte enables, alignment check and load extension select
// rev 1.0
// ============================================================================
module mips_cpu_bytelane
  import mips_cpu_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       is_signed,
  output logic [3:0] byteenable,
  output logic       misaligned,
  output logic [3:0] ld_ext
);

  always_comb begin
    byteenable = 4'b1111;
    misaligned = 1'b0;
    ld_ext     = c_alu_ldw;
    case (size)
      c_sz_byte: begin
        byteenable = 4'b0001 << addr_lo;
        ld_ext     = is_signed ? c_alu_ldb : c_alu_ldbu;
      end
      c_sz_half: begin
        byteenable = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
        ld_ext     = is_signed ? c_alu_ldh : c_alu_ldhu;
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// mips_cpu_sequencer: multicycle instruction-cycle FSM and datapath strobes
// rev 1.0
// ============================================================================
module mips_cpu_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic ENABLE_SUBWORD = 1'b1,
  parameter logic ENABLE_MULDIV  = 1'b1,
  parameter int   BE_WIDTH       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          fncode,
  input  logic [4:0]          regimm,
  input  logic                waitrequest,
  input  logic [1:0]          addr_lo,
  input  logic                muldiv_busy,
  input  logic                target_zero,
  output logic [2:0]          state,
  output logic                active,
  output logic [1:0]          regdst,
  output logic                regwrite,
  output logic                iord,
  output logic                irwrite,
  output logic                pcwrite,
  output logic [1:0]          pcsource,
  output logic                pcwritecond,
  output logic                jump,
  output logic                memread,
  output logic                memwrite,
  output logic [BE_WIDTH-1:0] byteenable,
  output logic                memtoreg,
  output logic [3:0]          aluop,
  output logic                alusrca,
  output logic [2:0]          alusrcb,
  output logic                muldivwrite,
  output logic                illegal,
  output logic                misaligned
);

  if (BE_WIDTH != 4) begin : g_be_width_check
    $error("mips_cpu_sequencer: BE_WIDTH must be 4");
  end

  state_t     state_q, state_d;
  iclass_t    w_iclass;
  logic [3:0] w_lane_be;
  logic       w_lane_mis;
  logic [3:0] w_lane_ext;
  logic [3:0] w_be;

  assign w_iclass   = classify(opcode, fncode, regimm, ENABLE_SUBWORD, ENABLE_MULDIV);
  assign state      = state_q;
  assign active     = (state_q != HALT);
  assign byteenable = w_be;

  mips_cpu_bytelane u_bytelane (
    .size       (opcode[1:0]),
    .addr_lo    (addr_lo),
    .is_signed  (~opcode[2]),
    .byteenable (w_lane_be),
    .misaligned (w_lane_mis),
    .ld_ext     (w_lane_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    regdst      = c_dst_rt;
    regwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcsource    = c_pcs_alu;
    pcwritecond = 1'b0;
    jump        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    w_be        = 4'b0000;
    memtoreg    = 1'b0;
    aluop       = c_alu_add;
    alusrca     = 1'b0;
    alusrcb     = c_srcb_reg;
    muldivwrite = 1'b0;
    illegal     = 1'b0;
    misaligned  = 1'b0;

    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = c_srcb_four;
        w_be    = 4'b1111;
        irwrite = ~waitrequest;
        pcwrite = ~waitrequest;
        if (!waitrequest) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = c_srcb_immsh;
        if (w_iclass == IC_ILLEGAL) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        state_d = FETCH;
        case (w_iclass)
          IC_RALU: begin
            alusrca  = 1'b1;
            aluop    = c_alu_funct;
            regdst   = c_dst_rd;
            regwrite = 1'b1;
          end
          IC_ALUI: begin
            alusrca  = 1'b1;
            alusrcb  = c_srcb_immz;
            regwrite = 1'b1;
            case (opcode)
              c_op_andi: aluop = c_alu_and;
              c_op_ori:  aluop = c_alu_or;
              c_op_xori: aluop = c_alu_xor;
              default: begin
                aluop   = c_alu_add;
                alusrcb = c_srcb_imm;
              end
            endcase
          end
          IC_BEQ, IC_BRANCH, IC_BRLINK: begin
            alusrca     = 1'b1;
            pcwritecond = 1'b1;
            pcsource    = c_pcs_aluout;
            if (w_iclass == IC_BEQ) aluop = c_alu_sub;
            else                    aluop = regimm[0] ? c_alu_gez : c_alu_ltz;
            if (w_iclass == IC_BRLINK) state_d = EXEC2;
          end
          IC_J, IC_JAL, IC_JR, IC_JALR: begin
            jump     = 1'b1;
            pcwrite  = 1'b1;
            alusrca  = 1'b1;
            pcsource = (w_iclass == IC_JR || w_iclass == IC_JALR) ? c_pcs_reg : c_pcs_jump;
            // A jump to address 0 is the program's exit; the link write is skipped
            if (target_zero)                                   state_d = HALT;
            else if (w_iclass == IC_JAL || w_iclass == IC_JALR) state_d = EXEC2;
          end
          IC_LOAD, IC_STORE: begin
            alusrca = 1'b1;
            alusrcb = c_srcb_imm;
            iord    = 1'b1;
            if (w_lane_mis) begin
              misaligned = 1'b1;
            end else begin
              w_be     = w_lane_be;
              memread  = (w_iclass == IC_LOAD);
              memwrite = (w_iclass == IC_STORE);
              if (waitrequest)                state_d = EXEC1;
              else if (w_iclass == IC_LOAD)   state_d = EXEC2;
            end
          end
          IC_MULDIV: begin
            alusrca     = 1'b1;
            aluop       = c_alu_funct;
            muldivwrite = 1'b1;
            state_d     = EXEC2;
          end
          IC_MTHILO: begin
            alusrca = 1'b1;
            aluop   = c_alu_funct;
            if (muldiv_busy) state_d = EXEC1;
            else             muldivwrite = 1'b1;
          end
          IC_MFHILO: begin
            aluop  = c_alu_funct;
            regdst = c_dst_rd;
            if (muldiv_busy) state_d = EXEC1;
            else             regwrite = 1'b1;
          end
          default: state_d = FETCH;
        endcase
      end
      EXEC2: begin
        state_d = FETCH;
        case (w_iclass)
          IC_LOAD: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            aluop    = w_lane_ext;
          end
          IC_MULDIV: if (muldiv_busy) state_d = EXEC2;
          IC_JAL, IC_JALR, IC_BRLINK: begin
            regwrite = 1'b1;
            aluop    = c_alu_link;
            regdst   = (w_iclass == IC_JALR) ? c_dst_rd : c_dst_ra;
          end
          default: state_d = FETCH;
        endcase
      end
      EXEC3:   state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    if (reset) begin
      regwrite    = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      muldivwrite = 1'b0;
      w_be        = 4'b0000;
      illegal     = 1'b0;
      misaligned  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mips_cpu_sequencer: directed instruction vectors with fixed expectations
// rev 1.0
// ============================================================================
module tb_mips_cpu_sequencer;
  import mips_cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] fncode;
  logic [4:0] regimm;
  logic       waitrequest;
  logic [1:0] addr_lo;
  logic       muldiv_busy;
  logic       target_zero;
  logic [2:0] state;
  logic       active;
  logic [1:0] regdst;
  logic       regwrite;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic [1:0] pcsource;
  logic       pcwritecond;
  logic       jump;
  logic       memread;
  logic       memwrite;
  logic [3:0] byteenable;
  logic       memtoreg;
  logic [3:0] aluop;
  logic       alusrca;
  logic [2:0] alusrcb;
  logic       muldivwrite;
  logic       illegal;
  logic       misaligned;

  int n_total = 0;
  int n_bad   = 0;
  int n_cnt;

  always #5 clk = ~clk;

  mips_cpu_sequencer #(
    .ENABLE_SUBWORD (1'b1),
    .ENABLE_MULDIV  (1'b1),
    .BE_WIDTH       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .fncode      (fncode),
    .regimm      (regimm),
    .waitrequest (waitrequest),
    .addr_lo     (addr_lo),
    .muldiv_busy (muldiv_busy),
    .target_zero (target_zero),
    .state       (state),
    .active      (active),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .iord        (iord),
    .irwrite     (irwrite),
    .pcwrite     (pcwrite),
    .pcsource    (pcsource),
    .pcwritecond (pcwritecond),
    .jump        (jump),
    .memread     (memread),
    .memwrite    (memwrite),
    .byteenable  (byteenable),
    .memtoreg    (memtoreg),
    .aluop       (aluop),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .muldivwrite (muldivwrite),
    .illegal     (illegal),
    .misaligned  (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; fncode = 6'h00; regimm = 5'h00;
    waitrequest = 1'b0; addr_lo = 2'd0; muldiv_busy = 1'b0; target_zero = 1'b0;
    tick; tick; settle;
    check("rst_state",   state, FETCH);
    check("rst_memread", memread, 0);
    check("rst_irwrite", irwrite, 0);
    check("rst_be",      byteenable, 0);

    reset = 1'b0; settle;
    check("fetch_active",  active, 1);
    check("fetch_memread", memread, 1);
    check("fetch_irwrite", irwrite, 1);
    check("fetch_srcb",    alusrcb, 1);
    check("fetch_be",      byteenable, 4'b1111);

    // fetch stall
    waitrequest = 1'b1; settle;
    check("fstall_irwrite", irwrite, 0);
    check("fstall_pcwrite", pcwrite, 0);
    check("fstall_memread", memread, 1);
    tick;
    waitrequest = 1'b0; opcode = 6'h00; fncode = 6'h21; settle;
    check("fstall_state", state, FETCH);

    // ADDU
    tick; settle;
    check("addu_dec_state", state, DECODE);
    check("addu_dec_srcb",  alusrcb, 3);
    check("addu_dec_rw",    regwrite, 0);
    tick; settle;
    check("addu_e1_state",  state, EXEC1);
    check("addu_e1_rw",     regwrite, 1);
    check("addu_e1_regdst", regdst, 1);
    tick; settle;
    check("addu_done_state", state, FETCH);
    check("addu_done_rw",    regwrite, 0);

    // LW, two waitrequest cycles in EXEC1
    opcode = 6'h23; addr_lo = 2'd0;
    tick; tick;
    n_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      waitrequest = (c < 2); settle;
      check("lw_e1_state", state, EXEC1);
      if (memread) n_cnt++;
      tick;
    end
    waitrequest = 1'b0;
    check("lw_memread_cycles", n_cnt, 3);
    settle;
    check("lw_e2_state",    state, EXEC2);
    check("lw_e2_rw",       regwrite, 1);
    check("lw_e2_memtoreg", memtoreg, 1);
    check("lw_e2_memread",  memread, 0);
    check("lw_e2_aluop",    aluop, 13);
    tick; settle;
    check("lw_done_state", state, FETCH);

    // SB at byte 2
    opcode = 6'h28; addr_lo = 2'd2;
    tick; tick; settle;
    check("sb_be",       byteenable, 4'b0100);
    check("sb_memwrite", memwrite, 1);
    check("sb_mis",      misaligned, 0);
    tick; settle;
    check("sb_done_state", state, FETCH);

    // SH misaligned
    opcode = 6'h29; addr_lo = 2'd1;
    tick; tick; settle;
    check("sh_mis",      misaligned, 1);
    check("sh_memwrite", memwrite, 0);
    check("sh_be",       byteenable, 0);
    tick; settle;
    check("sh_next_state", state, FETCH);
    check("sh_mis_clear",  misaligned, 0);

    // LH at upper half, then LBU at top byte
    opcode = 6'h21; addr_lo = 2'd2;
    tick; tick; settle;
    check("lh_be",  byteenable, 4'b1100);
    tick; settle;
    check("lh_ext", aluop, 11);
    tick;
    opcode = 6'h24; addr_lo = 2'd3;
    tick; tick; settle;
    check("lbu_be", byteenable, 4'b1000);
    tick; settle;
    check("lbu_ext", aluop, 10);
    tick; settle;
    check("lbu_done_state", state, FETCH);

    // LW misaligned
    opcode = 6'h23; addr_lo = 2'd2;
    tick; tick; settle;
    check("lw_mis",     misaligned, 1);
    check("lw_mis_rd",  memread, 0);
    tick; addr_lo = 2'd0;

    // MULT with 5 busy cycles in EXEC2
    opcode = 6'h00; fncode = 6'h18;
    tick; tick; settle;
    check("mult_e1_state", state, EXEC1);
    n_cnt = muldivwrite ? 1 : 0;
    tick;
    for (int c = 0; c < 5; c++) begin
      muldiv_busy = 1'b1; settle;
      check("mult_e2_hold", state, EXEC2);
      if (muldivwrite) n_cnt++;
      tick;
    end
    muldiv_busy = 1'b0; settle;
    check("mult_e2_release", state, EXEC2);
    if (muldivwrite) n_cnt++;
    tick; settle;
    check("mult_done_state", state, FETCH);
    check("mult_mdw_cycles", n_cnt, 1);

    // MFLO stalls on busy
    fncode = 6'h12;
    tick; tick;
    muldiv_busy = 1'b1; settle;
    check("mflo_stall_rw", regwrite, 0);
    tick;
    muldiv_busy = 1'b0; settle;
    check("mflo_state", state, EXEC1);
    check("mflo_rw",    regwrite, 1);
    tick; settle;
    check("mflo_done_state", state, FETCH);

    // JAL takes link writeback in EXEC2
    opcode = 6'h03;
    tick; tick; settle;
    check("jal_pcwrite",  pcwrite, 1);
    check("jal_pcsource", pcsource, 2);
    check("jal_jump",     jump, 1);
    tick; settle;
    check("jal_e2_rw",     regwrite, 1);
    check("jal_e2_regdst", regdst, 2);
    tick; settle;
    check("jal_done_state", state, FETCH);

    // JR to zero halts
    opcode = 6'h00; fncode = 6'h08; target_zero = 1'b1;
    tick; tick; settle;
    check("jr_pcwrite",  pcwrite, 1);
    check("jr_pcsource", pcsource, 3);
    tick; settle;
    check("jr_halt_state",  state, HALT);
    check("jr_halt_active", active, 0);
    check("jr_halt_rd",     memread, 0);
    tick; settle;
    check("halt_absorb", state, HALT);
    reset = 1'b1;
    tick; settle;
    check("halt_rst_state",  state, FETCH);
    check("halt_rst_active", active, 1);
    check("halt_rst_rd",     memread, 0);
    reset = 1'b0; target_zero = 1'b0;

    // illegal opcode
    opcode = 6'h3F;
    tick; settle;
    check("ill_state", state, DECODE);
    check("ill_pulse", illegal, 1);
    tick; settle;
    check("ill_next_state", state, FETCH);
    check("ill_clear",      illegal, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
